// File: rtl/timer_apb_sequencer.sv
// APB master that runs one timer job on the 8-bit timer's register slave:
// load TDR, pulse TCR load, enable counting, poll TSR for a flag, clear TSR,
// stop the timer and report done / err / status.
module timer_apb_sequencer #(
    parameter logic [7:0] ADDR_TCR  = 8'h00,
    parameter logic [7:0] ADDR_TDR  = 8'h01,
    parameter logic [7:0] ADDR_TSR  = 8'h02,
    parameter int         LOAD_BIT  = 7,
    parameter int         EN_BIT    = 4,
    parameter logic [7:0] TSR_MASK  = 8'h03,
    parameter int         POLL_GAP  = 16,
    parameter int         MAX_POLLS = 255
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] cfg_tdr,
    input  logic [7:0] cfg_tcr,
    output logic       busy,
    output logic       done,
    output logic [1:0] err,
    output logic [7:0] status,
    output logic       m_psel,
    output logic       m_penable,
    output logic       m_pwrite,
    output logic [7:0] m_paddr,
    output logic [7:0] m_pwdata,
    input  logic [7:0] m_prdata,
    input  logic       m_pready,
    input  logic       m_pslverr
);

    localparam logic [7:0]  LOAD_M   = 8'(1 << LOAD_BIT);
    localparam logic [7:0]  EN_M     = 8'(1 << EN_BIT);
    localparam logic [15:0] GAP_LD   = 16'(POLL_GAP);
    localparam logic [7:0]  POLL_LIM = 8'(MAX_POLLS);

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_SLV  = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;
    localparam logic [1:0] ERR_STOP = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_TDR, S_LOAD, S_RUN, S_POLL, S_GAP, S_CLR, S_STOP, S_DONE
    } state_t;

    // Bus phase of the current job step; P_IDLE is the mandatory psel=0 cycle.
    typedef enum logic [1:0] { P_IDLE, P_SETUP, P_ACCESS } phase_t;

    typedef struct packed {
        logic       write;
        logic [7:0] addr;
        logic [7:0] wdata;
    } apb_req_t;

    state_t     st, st_nxt;
    phase_t     ph, ph_nxt;
    logic [7:0] tdr_q, tcr_q, poll_cnt, poll_inc;
    logic [15:0] gap_cnt;
    logic [1:0] cause;
    logic       stop_pend;
    logic       xfer_done, job_start, stop_hit, flag, timeout, stoppable;

    apb_req_t   req;
    logic       psel_d, penable_d, busy_d, done_d;

    // Transfer issued by each bus step, built from the captured configuration.
    function automatic apb_req_t step_req(input state_t s, input logic [7:0] tdr,
                                          input logic [7:0] tcr);
        apb_req_t r;
        r = '0;
        case (s)
            S_TDR:  begin r.write = 1'b1; r.addr = ADDR_TDR; r.wdata = tdr; end
            S_LOAD: begin r.write = 1'b1; r.addr = ADDR_TCR; r.wdata = (tcr | LOAD_M) & ~EN_M; end
            S_RUN:  begin r.write = 1'b1; r.addr = ADDR_TCR; r.wdata = (tcr & ~LOAD_M) | EN_M; end
            S_POLL: begin r.write = 1'b0; r.addr = ADDR_TSR; r.wdata = 8'h00; end
            S_CLR:  begin r.write = 1'b1; r.addr = ADDR_TSR; r.wdata = 8'h00; end
            S_STOP: begin r.write = 1'b1; r.addr = ADDR_TCR; r.wdata = tcr & ~(LOAD_M | EN_M); end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Shared decode of the current cycle's bus and job conditions.
    always_comb begin
        xfer_done = (ph == P_ACCESS) && m_pready;
        job_start = (st == S_IDLE) && start;
        stop_hit  = stop || stop_pend;
        flag      = (m_prdata & TSR_MASK) != 8'h00;
        poll_inc  = (poll_cnt == 8'hFF) ? poll_cnt : poll_cnt + 8'd1;
        timeout   = poll_inc >= POLL_LIM;
        stoppable = st inside {S_TDR, S_LOAD, S_RUN, S_POLL, S_GAP, S_CLR};
    end

    // State register: job step and bus phase.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            st <= S_IDLE;
            ph <= P_IDLE;
        end else begin
            st <= st_nxt;
            ph <= ph_nxt;
        end
    end

    // Next-state: step sequencing, bus phase progression and error cause.
    always_comb begin
        st_nxt = st;
        ph_nxt = ph;
        cause  = ERR_NONE;
        unique case (st)
            S_IDLE: begin
                // The first SETUP is issued on the very edge that accepts start.
                if (start) begin
                    st_nxt = S_TDR;
                    ph_nxt = P_SETUP;
                end
            end
            S_DONE: begin
                st_nxt = S_IDLE;
                ph_nxt = P_IDLE;
            end
            S_GAP: begin
                if (stop_hit) begin
                    st_nxt = S_STOP;
                    cause  = ERR_STOP;
                end else if (gap_cnt <= 16'd1) begin
                    st_nxt = S_POLL;
                end
            end
            default: begin
                unique case (ph)
                    P_IDLE: begin
                        // No transfer in flight, so a stop can act right away.
                        if (stop_hit && stoppable) begin
                            st_nxt = S_STOP;
                            cause  = ERR_STOP;
                        end else begin
                            ph_nxt = P_SETUP;
                        end
                    end
                    P_SETUP: ph_nxt = P_ACCESS;
                    P_ACCESS: begin
                        if (m_pready) begin
                            ph_nxt = P_IDLE;
                            // Priority: slave error > flag found > stop > timeout.
                            if (m_pslverr) begin
                                cause  = ERR_SLV;
                                st_nxt = (st == S_STOP) ? S_DONE : S_STOP;
                            end else if (st == S_STOP) begin
                                st_nxt = S_DONE;
                            end else if (st == S_POLL && flag) begin
                                st_nxt = S_CLR;
                            end else if (stop_hit) begin
                                cause  = ERR_STOP;
                                st_nxt = S_STOP;
                            end else begin
                                case (st)
                                    S_TDR:  st_nxt = S_LOAD;
                                    S_LOAD: st_nxt = S_RUN;
                                    S_RUN:  st_nxt = S_POLL;
                                    S_POLL: begin
                                        if (timeout) begin
                                            cause  = ERR_TMO;
                                            st_nxt = S_STOP;
                                        end else begin
                                            st_nxt = S_GAP;
                                        end
                                    end
                                    default: st_nxt = S_STOP;
                                endcase
                            end
                        end
                    end
                    default: ph_nxt = P_IDLE;
                endcase
            end
        endcase
    end

    // Output decode: next values of the registered bus and handshake outputs.
    always_comb begin
        req       = step_req(st_nxt, job_start ? cfg_tdr : tdr_q,
                             job_start ? cfg_tcr : tcr_q);
        psel_d    = (ph_nxt == P_SETUP) || (ph_nxt == P_ACCESS);
        penable_d = (ph_nxt == P_ACCESS);
        busy_d    = !(st_nxt inside {S_IDLE, S_DONE});
        done_d    = (st_nxt == S_DONE);
    end

    // Registered outputs; reset drops the bus immediately without a W_STOP.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            m_psel    <= 1'b0;
            m_penable <= 1'b0;
            m_pwrite  <= 1'b0;
            m_paddr   <= 8'h00;
            m_pwdata  <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            m_psel    <= psel_d;
            m_penable <= penable_d;
            m_pwrite  <= psel_d & req.write;
            m_paddr   <= psel_d ? req.addr  : 8'h00;
            m_pwdata  <= psel_d ? req.wdata : 8'h00;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // Job datapath: captured config, poll/gap counters, first-cause error, status.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tdr_q     <= 8'h00;
            tcr_q     <= 8'h00;
            poll_cnt  <= 8'h00;
            gap_cnt   <= 16'h0000;
            err       <= ERR_NONE;
            status    <= 8'h00;
            stop_pend <= 1'b0;
        end else if (job_start) begin
            tdr_q     <= cfg_tdr;
            tcr_q     <= cfg_tcr;
            poll_cnt  <= 8'h00;
            err       <= ERR_NONE;
            status    <= 8'h00;
            stop_pend <= 1'b0;
        end else begin
            if (err == ERR_NONE && cause != ERR_NONE)
                err <= cause;
            if (xfer_done && st == S_POLL && !m_pslverr) begin
                if (flag)
                    status <= m_prdata;
                else
                    poll_cnt <= poll_inc;
            end
            if (st_nxt == S_GAP && st != S_GAP)
                gap_cnt <= GAP_LD;
            else if (st == S_GAP)
                gap_cnt <= gap_cnt - 16'd1;
            // A stop seen mid-transfer is held until that transfer completes.
            stop_pend <= (ph != P_IDLE) && !xfer_done && stoppable && (stop_pend || stop);
        end
    end

endmodule
